// File: rtl/bcd_updown_display.sv
// Multi-digit BCD up/down counter with a prescaled count tick and active-low 7-segment decode.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_updown_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_PERIOD = 50_000_000,
  parameter int PRESCALE_W  = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    tick,
  output logic                    wrap
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICK_PERIOD - 1);

  logic [PRESCALE_W-1:0]   prescaler;
  logic                    step;
  logic [4*NUM_DIGITS-1:0] bcd_stepped;
  logic [4*NUM_DIGITS-1:0] load_clean;
  logic                    wrap_next;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign step = en && (prescaler == PRESC_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset || load)
      prescaler <= '0;
    else if (en)
      prescaler <= step ? '0 : prescaler + PRESCALE_W'(1);
  end

  // Ripple carry/borrow from digit 0 upward; leftover carry out of the top digit is the wrap.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    bcd_stepped = bcd;
    carry       = 1'b1;
    d           = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d = bcd[4*i +: 4];
      if (carry) begin
        if (!dir) begin
          if (d == 4'd9) d = '0;
          else begin
            d     = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin
            d     = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
      bcd_stepped[4*i +: 4] = d;
    end
    wrap_next = carry;
  end

  always_comb begin
    load_clean = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      load_clean[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? '0 : load_value[4*i +: 4];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bcd  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      bcd  <= load_clean;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (step) begin
      bcd  <= bcd_stepped;
      tick <= 1'b1;
      wrap <= wrap_next;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; a digit blanks while it and everything above it is zero.
  always_comb begin
    logic        upper_zero;
    int unsigned idx;
    hex        = '1;
    upper_zero = 1'b1;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      idx        = NUM_DIGITS - 1 - k;
      upper_zero = upper_zero && (bcd[4*idx +: 4] == 4'd0);
      if (idx != 0 && upper_zero)
        hex[7*idx +: 7] = '1;
      else
        hex[7*idx +: 7] = seg7(bcd[4*idx +: 4]);
    end
  end
`else
  always_comb begin
    hex = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      hex[7*i +: 7] = seg7(bcd[4*i +: 4]);
  end
`endif

endmodule

// File: tb/tb_bcd_updown_display.sv
// Bench for bcd_updown_display (2 digits, tick period 4): vector table, corner sequences,
// and randomized traffic against an integer-valued reference model.
module tb_bcd_updown_display;

  localparam int ND  = 2;
  localparam int TP  = 4;
  localparam int MOD = 100;

  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};

  logic        clk = 1'b0;
  logic        reset = 1'b1, en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [7:0]  load_value = '0;
  logic [7:0]  bcd;
  logic [13:0] hex;
  logic        tick, wrap;

  always #5 clk = ~clk;

  bcd_updown_display #(.NUM_DIGITS(ND), .TICK_PERIOD(TP)) dut (
    .CLOCK_50(clk), .reset(reset), .en(en), .dir(dir), .load(load),
    .load_value(load_value), .bcd(bcd), .hex(hex), .tick(tick), .wrap(wrap)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] exp_bcd(input int v);
    logic [7:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [13:0] exp_hex(input int v);
    logic [13:0] r = '1;
    for (int i = 0; i < ND; i++) begin
      r[7*i +: 7] = SEG[(v / pow10(i)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < pow10(i)) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  function automatic int clean_val(input logic [7:0] lv);
    int r = 0;
    int d;
    for (int i = 0; i < ND; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      r = r + d * pow10(i);
    end
    return r;
  endfunction

  // Reference model: count held as a plain integer, prescaler as a cycle counter.
  int m_pc = 0, m_val = 0;
  bit m_tick = 0, m_wrap = 0, m_ok = 0;

  task automatic model_update();
    if (reset) begin
      m_pc = 0; m_val = 0; m_tick = 0; m_wrap = 0; m_ok = 1;
    end else if (load) begin
      m_pc = 0; m_val = clean_val(load_value); m_tick = 0; m_wrap = 0;
    end else if (en && m_pc == TP - 1) begin
      m_pc = 0;
      m_tick = 1;
      if (!dir) begin
        m_wrap = (m_val == MOD - 1);
        m_val  = (m_val + 1) % MOD;
      end else begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + MOD - 1) % MOD;
      end
    end else begin
      if (en) m_pc++;
      m_tick = 0; m_wrap = 0;
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    #1;
    model_update();
    if (m_ok) begin
      chk("model_bcd",  32'(bcd),  32'(exp_bcd(m_val)));
      chk("model_hex",  32'(hex),  32'(exp_hex(m_val)));
      chk("model_tick", 32'(tick), 32'(m_tick));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit d, input bit l, input logic [7:0] lv);
    reset = r; en = e; dir = d; load = l; load_value = lv;
  endtask

  typedef struct {
    bit         rst, e, d, ld;
    logic [7:0] lv;
    int         rep;
    logic [7:0] eb;
    bit         et, ew;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{1, 0, 0, 0, 8'h00, 2, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 3, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 1, 8'h01, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 3, 8'h01, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 1, 8'h02, 1, 0});
    tbl.push_back('{0, 1, 0, 1, 8'h98, 1, 8'h98, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 3, 8'h98, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 1, 8'h99, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 3, 8'h99, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 1, 8'h00, 1, 1});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 1, 1, 8'h00, 1, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 8'h00, 3, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 8'h00, 1, 8'h99, 1, 1});
    tbl.push_back('{0, 1, 1, 0, 8'h00, 3, 8'h99, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 8'h00, 1, 8'h98, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 8'h3C, 1, 8'h30, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 8'hA7, 1, 8'h07, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 8'h00, 5, 8'h07, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 2, 8'h07, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 3, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 1, 8'h01, 1, 0});

    foreach (tbl[n]) begin
      drive(tbl[n].rst, tbl[n].e, tbl[n].d, tbl[n].ld, tbl[n].lv);
      for (int r = 0; r < tbl[n].rep; r++) begin
        clk_cycle();
        chk($sformatf("tbl%0d_bcd", n),  32'(bcd),  32'(tbl[n].eb));
        chk($sformatf("tbl%0d_tick", n), 32'(tick), 32'(tbl[n].et));
        chk($sformatf("tbl%0d_wrap", n), 32'(wrap), 32'(tbl[n].ew));
      end
    end

    // Count 00..10 over 40 enabled cycles.
    drive(1, 0, 0, 0, 8'h00);
    clk_cycle();
    chk("rst_hex", 32'(hex), 32'(exp_hex(0)));
    drive(0, 1, 0, 0, 8'h00);
    for (int c = 1; c <= 40; c++) begin
      clk_cycle();
      chk($sformatf("run%0d_tick", c), 32'(tick), 32'((c % 4) == 0));
      chk($sformatf("run%0d_bcd", c),  32'(bcd),  32'(exp_bcd(c / 4)));
    end
    chk("ten_hex_lo", 32'(hex[6:0]),  32'(7'b1000000));
    chk("ten_hex_hi", 32'(hex[13:7]), 32'(7'b1111001));

    // Pause mid-period: prescaler holds, step lands on the second re-enabled cycle.
    drive(1, 0, 0, 0, 8'h00);
    clk_cycle();
    drive(0, 1, 0, 0, 8'h00);
    clk_cycle();
    clk_cycle();
    drive(0, 0, 0, 0, 8'h00);
    for (int c = 0; c < 10; c++) begin
      clk_cycle();
      chk("pause_bcd",  32'(bcd),  32'h00);
      chk("pause_tick", 32'(tick), 32'h0);
    end
    drive(0, 1, 0, 0, 8'h00);
    clk_cycle();
    chk("resume1_tick", 32'(tick), 32'h0);
    clk_cycle();
    chk("resume2_tick", 32'(tick), 32'h1);
    chk("resume2_bcd",  32'(bcd),  32'h01);

    // Load coincident with the step strobe.
    drive(1, 0, 0, 0, 8'h00);
    clk_cycle();
    drive(0, 1, 0, 0, 8'h00);
    for (int c = 0; c < 3; c++) clk_cycle();
    drive(0, 1, 0, 1, 8'h3C);
    clk_cycle();
    chk("ldstep_bcd",  32'(bcd),  32'h30);
    chk("ldstep_tick", 32'(tick), 32'h0);
    chk("ldstep_wrap", 32'(wrap), 32'h0);
    drive(0, 1, 0, 0, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      clk_cycle();
      chk($sformatf("after_ld%0d_tick", c), 32'(tick), 32'(c == 4));
    end
    chk("after_ld_bcd", 32'(bcd), 32'h31);

    // Leading-digit display for a single-digit count and after reset.
    drive(0, 0, 0, 1, 8'h05);
    clk_cycle();
    chk("five_hex_lo", 32'(hex[6:0]), 32'(7'b0010010));
`ifdef LEADING_ZERO_BLANK_EN
    chk("five_hex_hi", 32'(hex[13:7]), 32'(7'b1111111));
`else
    chk("five_hex_hi", 32'(hex[13:7]), 32'(7'b1000000));
`endif
    drive(1, 0, 0, 0, 8'h00);
    clk_cycle();
    chk("zero_hex_lo", 32'(hex[6:0]), 32'(7'b1000000));
`ifdef LEADING_ZERO_BLANK_EN
    chk("zero_hex_hi", 32'(hex[13:7]), 32'(7'b1111111));
`else
    chk("zero_hex_hi", 32'(hex[13:7]), 32'(7'b1000000));
`endif

    // Randomized traffic checked by the model inside clk_cycle.
    drive(0, 1, 0, 0, 8'h00);
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      load       = ($urandom_range(0, 24) == 0);
      en         = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      load_value = 8'($urandom);
      clk_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_display.md
Name: bcd_updown_display

Overview:
Parametrised multi-digit decimal up/down counter with per-digit active-low 7-segment decode, for DE-series HEX displays. A programmable prescaler divides CLOCK_50 into count ticks. Adds enable, parallel load, run-time direction, and wrap/tick status pulses. Sits between board switches/keys and the HEXn outputs; also usable as a timebase/event counter for later CPU bring-up.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
TICK_PERIOD, 50_000_000, CLOCK_50 cycles per count step (>=1).
PRESCALE_W, $clog2(TICK_PERIOD) (min 1), prescaler register width.

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  1 = prescaler runs and ticks apply; 0 = freeze prescaler and count.
dir  input  1  0 = count up, 1 = count down; sampled on the tick cycle.
load  input  1  one-cycle parallel-load strobe.
load_value  input  4*NUM_DIGITS  BCD load value, digit i at [4i+3:4i].
bcd  output  4*NUM_DIGITS  registered count, digit i at [4i+3:4i].
hex  output  7*NUM_DIGITS  active-low segments, digit i at [7i+6:7i], bit0=a..bit6=g.
tick  output  1  one-cycle pulse on each applied count step.
wrap  output  1  one-cycle pulse when the count wraps (99..9->0 up, 0->99..9 down).

Behaviour:
- Reset (sync, active-high): prescaler=0, bcd=0, tick=0, wrap=0; hex shows "0" on every digit (7'b1000000).
- Priority per cycle: reset > load > tick step.
- Prescaler: when en=1, counts 0..TICK_PERIOD-1, then back to 0. Internal step strobe fires on the cycle prescaler==TICK_PERIOD-1. Exactly TICK_PERIOD cycles between steps. TICK_PERIOD=1 gives a step every enabled cycle.
- en=0: prescaler and bcd hold. tick and wrap are 0.
- Load: bcd<=load_value next cycle. Prescaler<=0. tick=0, wrap=0. Any digit >9 in load_value is loaded as 0. Load takes effect regardless of en.
- Step up: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. Carry out of the top digit: all digits 0 and wrap=1.
- Step down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. Borrow out of the top digit: all digits 9 and wrap=1.
- tick and wrap are registered and asserted in the same cycle the new bcd value appears. Latency: step strobe -> bcd/tick/wrap +1 cycle.
- A dir change mid-period does not reset the prescaler. It affects only the next step.
- hex is a combinational decode of registered bcd, zero added latency. Encodings:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other value = 1111111 (unreachable by construction).
- Reset or load asserted mid-period discards the partial prescaler count.
- Simultaneous load and step strobe: load wins, no tick, no wrap.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: any digit above digit 0 whose value and all higher digits' values are 0 shows 1111111 (blank). Digit 0 always displays, so a zero count shows a single "0". bcd is unaffected.
- Undefined: every digit always shows its decoded value, including leading zeros.

Test Plan:
(NUM_DIGITS=2, TICK_PERIOD=4 unless noted)
- Reset then en=1, dir=0 for 40 cycles -> tick every 4th cycle; bcd steps 00,01..10 with digit-0 carry at 09->10; hex[6:0]=1000000 and hex[13:7]=1111001 at 10.
- load 8'h98, en=1, dir=0 -> 98, 99, then 00 with wrap=1 for exactly one cycle coincident with tick.
- load 8'h00, dir=1 -> next step gives 99 and wrap=1; following step gives 98 and wrap=0.
- en=1 for 2 cycles, en=0 for 10 cycles, then en=1 -> step occurs 2 cycles after re-enable; bcd frozen while en=0.
- load asserted on the same cycle as a step strobe with load_value=8'h3C -> bcd=30 (invalid low digit forced to 0), tick=0; next step occurs 4 cycles later.
- With LEADING_ZERO_BLANK_EN defined, bcd=05 -> hex[13:7]=1111111 and hex[6:0]=0010010; after reset -> hex[13:7]=1111111 and hex[6:0]=1000000.
